// File: rtl/ab_seq_ctrl.sv
// "a then b" sequence detector with qualified sampling, a one-cycle hit pulse,
// a saturating hit counter and an optional hit budget that freezes detection.
module ab_seq_ctrl #(
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned MAX_HITS = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_i,
    input  logic             a_i,
    input  logic             b_i,
    input  logic             clear_i,
    output logic [1:0]       state_o,
    output logic             hit_o,
    output logic [CNT_W-1:0] hit_count_o,
    output logic             done_o
);

    localparam logic             BUDGET_EN = (MAX_HITS != 0);
    localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(MAX_HITS);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_GOT_A   = 2'b01,
        ST_DETECT  = 2'b10,
        ST_ILLEGAL = 2'b11
    } state_t;

    state_t           r_state;
    logic             r_hit;
    logic [CNT_W-1:0] r_count;
    logic             r_done;

    logic [1:0]       w_ns;
    logic             w_adv;
    logic             w_hit;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             w_budget_reached;

    // Next-state bits: 2'b11 decodes like GOT_A on the b bit, so it exits safely.
    always_comb begin
        w_ns[0]          = a_i & (r_state == ST_IDLE);
        w_ns[1]          = b_i & r_state[0];
        w_adv            = valid_i & ~r_done;
        w_hit            = w_adv & (w_ns == 2'b10);
        w_cnt_inc        = (r_count == CNT_MAX) ? r_count : r_count + CNT_W'(1);
        w_budget_reached = BUDGET_EN & (w_cnt_inc == CNT_LIMIT);
    end

    // Clear overrides any sample taken on the same edge, including a completing hit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_hit   <= 1'b0;
            r_count <= '0;
            r_done  <= 1'b0;
        end else if (clear_i) begin
            r_state <= ST_IDLE;
            r_hit   <= 1'b0;
            r_count <= '0;
            r_done  <= 1'b0;
        end else begin
            r_hit <= w_hit;
            if (r_done) begin
                r_state <= ST_IDLE;
            end else if (valid_i) begin
                r_state <= state_t'(w_ns);
            end
            if (w_hit) begin
                r_count <= w_cnt_inc;
                if (w_budget_reached) begin
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign state_o     = r_state;
    assign hit_o       = r_hit;
    assign hit_count_o = r_count;
    assign done_o      = r_done;

endmodule
